dr_ctrl_driver: RTL and testbench

Synchronous initiator for the dual-rail phase/read/load controller. It accepts a command from clocked logic over a valid/ready handshake and encodes it as a dual-rail DATA wavefront on PH0/PH1/Rd/Ld. It waits for both dual-rail responses R_c and R_m to complete, then drives NULL and waits for the responses to return to NULL. The captured responses are returned over a second valid/ready handshake. The block sits at the boundary between the clocked control domain and the delay-insensitive datapath.

---
 rtl/dr_ctrl_driver.sv | 185 ++++++++++++++++++
 tb/tb_dr_ctrl_driver.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dr_ctrl_driver.sv
// rtl/dr_ctrl_driver.sv - clocked initiator for the dual-rail phase/read/load controller
//
// Accepts one command over cmd_valid/cmd_ready and emits it as a dual-rail DATA wavefront.
// It waits for R_c and R_m to complete, returns the rails to NULL, and waits for the
// responses to return to NULL. The captured R_c/R_m values are then offered over
// rsp_valid/rsp_ready.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   cmd_valid/cmd_ready, cmd_*    command handshake and the four bits to encode
//   PH0_t..Ld_f                   registered dual-rail command rails (all 0 = NULL)
//   R_c_t, R_c_f, R_m_t, R_m_f    dual-rail responses, asynchronous to clk
//   rsp_valid/rsp_ready           response handshake; rsp_rc/rsp_rm carry the true-rail values
//   err, err_code                 sticky error: 1 illegal pair, 2 timeout WAIT_DATA, 3 timeout WAIT_NULL
//   busy                          high whenever the FSM is not in IDLE
//   mismatch                      only present with DR_ORACLE_CHECK_EN: sticky response-check flag
//
// Build option: define DR_ORACLE_CHECK_EN to compare captured responses with the
// expected controller equations.
module dr_ctrl_driver #(
    parameter int SYNC_STAGES = 2,
    parameter int TMO_W       = 8,
    parameter int TMO_MAX     = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_ph0,
    input  logic       cmd_ph1,
    input  logic       cmd_rd,
    input  logic       cmd_ld,
    output logic       PH0_t,
    output logic       PH0_f,
    output logic       PH1_t,
    output logic       PH1_f,
    output logic       Rd_t,
    output logic       Rd_f,
    output logic       Ld_t,
    output logic       Ld_f,
    input  logic       R_c_t,
    input  logic       R_c_f,
    input  logic       R_m_t,
    input  logic       R_m_f,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_rc,
    output logic       rsp_rm,
    output logic       err,
    output logic [1:0] err_code,
    output logic       busy
`ifdef DR_ORACLE_CHECK_EN
    ,
    output logic       mismatch
`endif
);

    typedef enum logic [2:0] {IDLE, DATA, WAIT_DATA, WAIT_NULL, RESP, ERR} state_t;

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_MAX - 1);

    state_t           state;
    logic [3:0]       sync_q [SYNC_STAGES];
    logic [TMO_W-1:0] tmo_cnt;
    logic [7:0]       rail_q;
    logic             rc_t, rc_f, rm_t, rm_f;
    logic             complete, null_s, illegal;

`ifdef DR_ORACLE_CHECK_EN
    logic [3:0]       cmd_q;
`endif

    // Every rail is a dedicated flop, so the delay-insensitive side never sees gating glitches.
    assign {PH0_t, PH0_f, PH1_t, PH1_f, Rd_t, Rd_f, Ld_t, Ld_f} = rail_q;

    assign {rc_t, rc_f, rm_t, rm_f} = sync_q[SYNC_STAGES-1];
    assign complete = (rc_t ^ rc_f) & (rm_t ^ rm_f);
    assign null_s   = ~(rc_t | rc_f | rm_t | rm_f);
    assign illegal  = (rc_t & rc_f) | (rm_t & rm_f);
    assign busy     = (state != IDLE);

    function automatic logic [7:0] encode(input logic ph0, input logic ph1,
                                          input logic rd,  input logic ld);
        return {ph0, ~ph0, ph1, ~ph1, rd, ~rd, ld, ~ld};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= {R_c_t, R_c_f, R_m_t, R_m_f};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rail_q    <= '0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rc    <= 1'b0;
            rsp_rm    <= 1'b0;
            err       <= 1'b0;
            err_code  <= 2'd0;
            tmo_cnt   <= '0;
`ifdef DR_ORACLE_CHECK_EN
            cmd_q     <= '0;
            mismatch  <= 1'b0;
`endif
        end else begin
            // Saturating count; the assignments below override it on a state change.
            if ((state == WAIT_DATA || state == WAIT_NULL) && tmo_cnt != '1)
                tmo_cnt <= tmo_cnt + 1'b1;

            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        rail_q    <= encode(cmd_ph0, cmd_ph1, cmd_rd, cmd_ld);
                        cmd_ready <= 1'b0;
                        state     <= DATA;
`ifdef DR_ORACLE_CHECK_EN
                        cmd_q     <= {cmd_ph0, cmd_ph1, cmd_rd, cmd_ld};
`endif
                    end else begin
                        // Stale non-NULL responses block new commands until they drain.
                        cmd_ready <= null_s;
                    end
                end
                DATA: begin
                    tmo_cnt <= '0;
                    state   <= WAIT_DATA;
                end
                WAIT_DATA: begin
                    // Completion on the last allowed cycle takes priority over the timeout.
                    if (complete) begin
                        rsp_rc  <= rc_t;
                        rsp_rm  <= rm_t;
                        rail_q  <= '0;
                        tmo_cnt <= '0;
                        state   <= WAIT_NULL;
`ifdef DR_ORACLE_CHECK_EN
                        if (rc_t != (~cmd_q[3] & cmd_q[2] & cmd_q[1]) ||
                            rm_t != (cmd_q[3] | (cmd_q[2] & cmd_q[0])))
                            mismatch <= 1'b1;
`endif
                    end else if (tmo_cnt == TMO_LAST) begin
                        rail_q   <= '0;
                        err      <= 1'b1;
                        err_code <= 2'd2;
                        state    <= ERR;
                    end
                end
                WAIT_NULL: begin
                    if (null_s) begin
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else if (tmo_cnt == TMO_LAST) begin
                        err      <= 1'b1;
                        err_code <= 2'd3;
                        state    <= ERR;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: ;  // ERR is left only through reset
            endcase

            // An illegal pair outranks every other transition, including completion.
            if (illegal && state != IDLE && state != ERR) begin
                rail_q    <= '0;
                cmd_ready <= 1'b0;
                rsp_valid <= 1'b0;
                err       <= 1'b1;
                err_code  <= 2'd1;
                state     <= ERR;
            end
        end
    end

endmodule

// File: tb/tb_dr_ctrl_driver.sv
// tb/tb_dr_ctrl_driver.sv - directed-vector bench for dr_ctrl_driver
module tb_dr_ctrl_driver;

    localparam int S = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cmd_valid = 1'b0, cmd_ready;
    logic cmd_ph0 = 1'b0, cmd_ph1 = 1'b0, cmd_rd = 1'b0, cmd_ld = 1'b0;
    logic PH0_t, PH0_f, PH1_t, PH1_f, Rd_t, Rd_f, Ld_t, Ld_f;
    logic R_c_t, R_c_f, R_m_t, R_m_f;
    logic rsp_valid, rsp_ready = 1'b0, rsp_rc, rsp_rm, err, busy;
    logic [1:0] err_code;
`ifdef DR_ORACLE_CHECK_EN
    logic mismatch;
`endif

    // Responder: 0 correct, 1 never completes, 2 R_m both rails high, 3 R_c forced true when PH0=1
    int         rmode = 0;
    logic       dly_on = 1'b0;
    logic       stale = 1'b0;
    logic [3:0] rsp_comb;
    logic [3:0] dly0 = 4'h0, dly1 = 4'h0;
    logic [3:0] rsp_sel;
    logic       data_in, e_rc, e_rm;

    int vectors = 0;
    int miscompares = 0;

    wire [7:0] rails = {PH0_t, PH0_f, PH1_t, PH1_f, Rd_t, Rd_f, Ld_t, Ld_f};

    dr_ctrl_driver #(.SYNC_STAGES(S), .TMO_W(8), .TMO_MAX(200)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ph0(cmd_ph0), .cmd_ph1(cmd_ph1), .cmd_rd(cmd_rd), .cmd_ld(cmd_ld),
        .PH0_t(PH0_t), .PH0_f(PH0_f), .PH1_t(PH1_t), .PH1_f(PH1_f),
        .Rd_t(Rd_t), .Rd_f(Rd_f), .Ld_t(Ld_t), .Ld_f(Ld_f),
        .R_c_t(R_c_t), .R_c_f(R_c_f), .R_m_t(R_m_t), .R_m_f(R_m_f),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rc(rsp_rc), .rsp_rm(rsp_rm),
        .err(err), .err_code(err_code), .busy(busy)
`ifdef DR_ORACLE_CHECK_EN
        , .mismatch(mismatch)
`endif
    );

    always #5 clk = ~clk;

    always_comb begin
        data_in  = (PH0_t ^ PH0_f) & (PH1_t ^ PH1_f) & (Rd_t ^ Rd_f) & (Ld_t ^ Ld_f);
        e_rc     = (~PH0_t & PH1_t & Rd_t) | ((rmode == 3) & PH0_t);
        e_rm     = PH0_t | (PH1_t & Ld_t);
        rsp_comb = 4'h0;
        if (data_in) begin
            case (rmode)
                1:       rsp_comb = 4'h0;
                2:       rsp_comb = {e_rc, ~e_rc, 2'b11};
                default: rsp_comb = {e_rc, ~e_rc, e_rm, ~e_rm};
            endcase
        end
    end

    always @(posedge clk) begin
        dly0 <= rsp_comb;
        dly1 <= dly0;
    end

    assign rsp_sel = (dly_on ? dly1 : rsp_comb) | {stale, 3'b000};
    assign {R_c_t, R_c_f, R_m_t, R_m_f} = rsp_sel;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cmd(input logic p0, input logic p1, input logic rd, input logic ld);
        int n = 0;
        while (!cmd_ready && n < 100) begin
            tick();
            n++;
        end
        chk("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
        cmd_ph0 = p0; cmd_ph1 = p1; cmd_rd = rd; cmd_ld = ld;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    // Counts the handshake cycle as 1, then every edge until rsp_valid is seen.
    task automatic wait_rsp(output int lat, output logic [7:0] rails_at_valid);
        lat = 1;
        while (!rsp_valid && lat < 60) begin
            tick();
            lat++;
        end
        rails_at_valid = rails;
        chk("rsp_valid_seen", {31'd0, rsp_valid}, 32'd1);
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    int         lat;
    logic [7:0] rv;

    initial begin
        // Reset state
        tick();
        chk("reset_state", {20'd0, rails, cmd_ready, rsp_valid, err, busy},
            32'd0);
        chk("reset_code", {30'd0, err_code}, 32'd0);
        rst = 1'b0;
        tick();
        chk("ready_after_reset", {31'd0, cmd_ready}, 32'd1);

        // ph0=0 ph1=1 rd=1 ld=1, 2-cycle responder: PH0_f PH1_t Rd_t Ld_t, rc=1 rm=1
        dly_on = 1'b1;
        do_cmd(1'b0, 1'b1, 1'b1, 1'b1);
        chk("rails_0111", {24'd0, rails}, 32'h6A);
        chk("busy_0111", {31'd0, busy}, 32'd1);
        wait_rsp(lat, rv);
        chk("latency_dly2", lat, 3 + 2*S + 4);
        chk("rails_null_at_valid", {24'd0, rv}, 32'd0);
        chk("rsp_0111", {30'd0, rsp_rc, rsp_rm}, 32'h3);
        chk("cmd_ready_in_resp", {31'd0, cmd_ready}, 32'd0);
        take_rsp();
        chk("rsp_cleared", {30'd0, rsp_valid, cmd_ready}, 32'd0);
        tick();
        chk("ready_after_rsp", {31'd0, cmd_ready}, 32'd1);

        // ph0=1 ph1=0 rd=0 ld=0, zero-delay responder: rc=0 rm=1, response held 5 cycles
        dly_on = 1'b0;
        do_cmd(1'b1, 1'b0, 1'b0, 1'b0);
        chk("rails_1000", {24'd0, rails}, 32'h95);
        wait_rsp(lat, rv);
        chk("latency_min", lat, 3 + 2*S);
        for (int i = 0; i < 5; i++) begin
            chk("resp_hold", {28'd0, rsp_valid, rsp_rc, rsp_rm, cmd_ready}, 32'b1010);
            tick();
        end
        take_rsp();
        tick();

        // Stale response in IDLE blocks cmd_ready without raising an error
        stale = 1'b1;
        repeat (S + 2) tick();
        chk("stale_blocks", {30'd0, cmd_ready, err}, 32'd0);
        stale = 1'b0;
        repeat (S + 2) tick();
        chk("stale_clears", {30'd0, cmd_ready, err}, 32'h2);

        // Never-completing responder: timeout code 2 exactly TMO_MAX cycles after WAIT_DATA entry
        rmode = 1;
        do_cmd(1'b0, 1'b1, 1'b1, 1'b0);
        repeat (199) @(posedge clk);
        tick();
        chk("tmo_not_yet", {31'd0, err}, 32'd0);
        tick();
        chk("tmo_err", {29'd0, err, err_code}, 32'h6);
        chk("tmo_rails_null", {24'd0, rails}, 32'd0);
        cmd_valid = 1'b1;
        repeat (5) tick();
        chk("tmo_stuck", {29'd0, cmd_ready, err, busy}, 32'h3);
        cmd_valid = 1'b0;
        do_reset();
        chk("tmo_reset_clears", {29'd0, err, err_code}, 32'd0);

        // R_m both rails high during WAIT_DATA: illegal outranks R_c completion
        rmode = 2;
        tick();
        do_cmd(1'b0, 1'b1, 1'b1, 1'b1);
        lat = 0;
        while (!err && lat < 20) begin
            tick();
            lat++;
        end
        chk("illegal_err", {29'd0, err, err_code}, 32'h5);
        chk("illegal_no_rsp", {23'd0, rsp_valid, rails}, 32'd0);
        do_reset();
        rmode = 0;

        // Reset asserted in WAIT_DATA clears the rails within the cycle
        dly_on = 1'b1;
        tick();
        do_cmd(1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        rst = 1'b1;
        #1;
        chk("async_reset", {22'd0, rails, rsp_valid, busy}, 32'd0);
        tick();
        rst = 1'b0;
        do_cmd(1'b0, 1'b1, 1'b0, 1'b1);
        wait_rsp(lat, rv);
        chk("post_reset_rsp", {29'd0, rsp_rc, rsp_rm, err}, 32'h2);
        take_rsp();

`ifdef DR_ORACLE_CHECK_EN
        // Wrong R_c for ph0=1 flags mismatch but still delivers the response
        rmode = 3;
        do_cmd(1'b1, 1'b0, 1'b0, 1'b0);
        wait_rsp(lat, rv);
        chk("oracle_bad", {29'd0, mismatch, rsp_rc, rsp_rm}, 32'h7);
        take_rsp();
        do_reset();
        rmode = 0;
        for (int c = 0; c < 16; c++) begin
            logic [3:0] cv;
            cv = 4'(c);
            do_cmd(cv[3], cv[2], cv[1], cv[0]);
            wait_rsp(lat, rv);
            chk("oracle_rc", {31'd0, rsp_rc}, {31'd0, ~cv[3] & cv[2] & cv[1]});
            chk("oracle_rm", {31'd0, rsp_rm}, {31'd0, cv[3] | (cv[2] & cv[0])});
            take_rsp();
        end
        chk("oracle_clean", {31'd0, mismatch}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
